// File: rtl/wb_port_arbiter_if.sv
// Register-file write-port sharing bundle: pipeline writeback, long-latency
// result channel, and the arbitrated write port with stall and pending status.
interface wb_port_arbiter_if #(
  parameter int WORD_SIZE = 32
);
  logic                 pipe_wb_valid;
  logic [4:0]           pipe_wb_rd;
  logic [WORD_SIZE-1:0] pipe_wb_data;
  logic                 lu_valid;
  logic [4:0]           lu_rd;
  logic [WORD_SIZE-1:0] lu_data;
  logic                 lu_ready;
  logic                 rf_we;
  logic [4:0]           rf_waddr;
  logic [WORD_SIZE-1:0] rf_wdata;
  logic                 pipe_stall;
  logic [31:0]          pending_mask;

  modport slave (
    input  pipe_wb_valid, pipe_wb_rd, pipe_wb_data, lu_valid, lu_rd, lu_data,
    output lu_ready, rf_we, rf_waddr, rf_wdata, pipe_stall, pending_mask
  );

  modport master (
    output pipe_wb_valid, pipe_wb_rd, pipe_wb_data, lu_valid, lu_rd, lu_data,
    input  lu_ready, rf_we, rf_waddr, rf_wdata, pipe_stall, pending_mask
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between pipeline writeback and a buffered
// long-latency unit; pipeline wins, buffered results drain into idle slots.
module wb_port_arbiter #(
  parameter int WORD_SIZE    = 32,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  wb_port_arbiter_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int AW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    FORCE   = 2'd2
  } state_t;

  state_t               state_r;
  logic [4:0]           rd_mem_r   [DEPTH];
  logic [WORD_SIZE-1:0] data_mem_r [DEPTH];
  logic [DEPTH-1:0]     live_r;
  logic [PW-1:0]        wptr_r;
  logic [PW-1:0]        rptr_r;
  logic [CW-1:0]        count_r;
  logic [AW-1:0]        age_r;
  logic                 rf_we_r;
  logic [4:0]           rf_waddr_r;
  logic [WORD_SIZE-1:0] rf_wdata_r;
  logic                 pipe_stall_r;
  logic [31:0]          pending_mask_r;

  logic                 pipe_go_s;
  logic                 empty_s;
  logic                 full_s;
  logic                 head_live_s;
  logic                 pop_s;
  logic                 pop_write_s;
  logic                 push_s;
  logic                 force_s;
  logic [CW-1:0]        count_next_s;
  logic [AW-1:0]        age_next_s;
  logic [DEPTH-1:0]     live_next_s;
  logic [4:0]           slot_rd_s [DEPTH];
  logic [31:0]          mask_next_s;

  // Slot arbitration, FIFO bookkeeping and WAW squash for the current cycle
  always_comb begin
    pipe_go_s    = bus.pipe_wb_valid && (bus.pipe_wb_rd != 5'd0) && !pipe_stall_r;
    empty_s      = (count_r == {CW{1'b0}});
    full_s       = (count_r == CW'(DEPTH));
    head_live_s  = !empty_s && live_r[rptr_r];
    // Dead heads leave regardless of the pipeline; live heads only use idle slots.
    pop_s        = !empty_s && (!live_r[rptr_r] || !pipe_go_s);
    pop_write_s  = head_live_s && !pipe_go_s;
    push_s       = bus.lu_valid && !full_s && (bus.lu_rd != 5'd0) &&
                   !(pipe_go_s && (bus.lu_rd == bus.pipe_wb_rd));
    count_next_s = count_r + CW'(push_s) - CW'(pop_s);
    force_s      = !pop_s && (full_s || (age_r == AW'(STARVE_LIMIT - 1)));
    age_next_s   = (empty_s || pop_s) ? {AW{1'b0}} :
                   (head_live_s && (age_r != AW'(STARVE_LIMIT))) ? age_r + AW'(1) : age_r;
    live_next_s  = {DEPTH{1'b0}};
    mask_next_s  = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_rd_s[i]   = (push_s && (wptr_r == PW'(i))) ? bus.lu_rd : rd_mem_r[i];
      live_next_s[i] = (push_s && (wptr_r == PW'(i))) ||
                       (live_r[i] && !(pop_s && (rptr_r == PW'(i))) &&
                        !(pipe_go_s && (rd_mem_r[i] == bus.pipe_wb_rd)));
      mask_next_s    = mask_next_s | ({31'd0, live_next_s[i]} << slot_rd_s[i]);
    end
  end

  // FSM, FIFO storage and registered write-port outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= IDLE;
      live_r         <= {DEPTH{1'b0}};
      wptr_r         <= {PW{1'b0}};
      rptr_r         <= {PW{1'b0}};
      count_r        <= {CW{1'b0}};
      age_r          <= {AW{1'b0}};
      rf_we_r        <= 1'b0;
      rf_waddr_r     <= 5'd0;
      rf_wdata_r     <= {WORD_SIZE{1'b0}};
      pipe_stall_r   <= 1'b0;
      pending_mask_r <= 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_mem_r[i]   <= 5'd0;
        data_mem_r[i] <= {WORD_SIZE{1'b0}};
      end
    end else begin
      if (push_s) begin
        rd_mem_r[wptr_r]   <= bus.lu_rd;
        data_mem_r[wptr_r] <= bus.lu_data;
        wptr_r             <= wptr_r + PW'(1);
      end
      if (pop_s) begin
        rptr_r <= rptr_r + PW'(1);
      end
      live_r         <= live_next_s;
      count_r        <= count_next_s;
      age_r          <= age_next_s;
      pending_mask_r <= mask_next_s;
      rf_we_r        <= pipe_go_s || pop_write_s;
      if (pipe_go_s) begin
        rf_waddr_r <= bus.pipe_wb_rd;
        rf_wdata_r <= bus.pipe_wb_data;
      end else if (pop_write_s) begin
        rf_waddr_r <= rd_mem_r[rptr_r];
        rf_wdata_r <= data_mem_r[rptr_r];
      end
      case (state_r)
        IDLE: begin
          pipe_stall_r <= 1'b0;
          state_r      <= push_s ? PENDING : IDLE;
        end
        PENDING: begin
          if (count_next_s == {CW{1'b0}}) begin
            state_r      <= IDLE;
            pipe_stall_r <= 1'b0;
          end else if (force_s) begin
            state_r      <= FORCE;
            pipe_stall_r <= 1'b1;
          end else begin
            state_r      <= PENDING;
            pipe_stall_r <= 1'b0;
          end
        end
        FORCE: begin
          pipe_stall_r <= 1'b0;
          state_r      <= (count_next_s == {CW{1'b0}}) ? IDLE : PENDING;
        end
        default: begin
          pipe_stall_r <= 1'b0;
          state_r      <= IDLE;
        end
      endcase
    end
  end

  assign bus.lu_ready     = !full_s;
  assign bus.rf_we        = rf_we_r;
  assign bus.rf_waddr     = rf_waddr_r;
  assign bus.rf_wdata     = rf_wdata_r;
  assign bus.pipe_stall   = pipe_stall_r;
  assign bus.pending_mask = pending_mask_r;

  wb_port_arbiter_chk u_chk (
    .clk           (clk),
    .rst           (rst),
    .pipe_wb_valid (bus.pipe_wb_valid),
    .pipe_stall    (pipe_stall_r)
  );
endmodule

// Protocol checker: the pipeline must not present a writeback while stalled.
module wb_port_arbiter_chk (
  input logic clk,
  input logic rst,
  input logic pipe_wb_valid,
  input logic pipe_stall
);
  a_no_wb_during_stall: assert property (@(posedge clk) disable iff (rst)
    !(pipe_wb_valid && pipe_stall))
    else $error("pipeline writeback presented during stall");
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: reset, drain latency, starvation and full
// forced drains, WAW squash and x0 handling, with hand-computed expectations.
module tb_wb_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total_s = 0;
  int   bad_s   = 0;
  int   ecnt_s  = 0;

  typedef struct {
    int          edge_n;
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t wlog_q[$];
  int  stall_q[$];

  wb_port_arbiter_if #(.WORD_SIZE(32)) bus ();

  wb_port_arbiter #(.WORD_SIZE(32), .DEPTH(2), .STARVE_LIMIT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_s++;
    if (obs !== exp) begin
      bad_s++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive requests (pipeline masked while stalled), then log outputs.
  task automatic tick(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                      input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
    bus.pipe_wb_valid = pv & ~bus.pipe_stall;
    bus.pipe_wb_rd    = prd;
    bus.pipe_wb_data  = pd;
    bus.lu_valid      = lv;
    bus.lu_rd         = lrd;
    bus.lu_data       = ld;
    @(posedge clk);
    #1;
    bus.pipe_wb_valid = 1'b0;
    bus.lu_valid      = 1'b0;
    if (bus.pipe_stall) stall_q.push_back(ecnt_s);
    if (bus.rf_we && (bus.rf_waddr != 5'd20))
      wlog_q.push_back('{ecnt_s, bus.rf_waddr, bus.rf_wdata});
    ecnt_s++;
  endtask

  task automatic clear_logs();
    wlog_q.delete();
    stall_q.delete();
    ecnt_s = 0;
  endtask

  task automatic busy(input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
    tick(1'b1, 5'd20, 32'hA000_0000 + 32'(ecnt_s), lv, lrd, ld);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    bus.pipe_wb_valid = 1'b0;
    bus.pipe_wb_rd    = 5'd0;
    bus.pipe_wb_data  = 32'd0;
    bus.lu_valid      = 1'b0;
    bus.lu_rd         = 5'd0;
    bus.lu_data       = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("rst_we",       64'(bus.rf_we),        64'd0);
    check_eq("rst_waddr",    64'(bus.rf_waddr),     64'd0);
    check_eq("rst_wdata",    64'(bus.rf_wdata),     64'd0);
    check_eq("rst_stall",    64'(bus.pipe_stall),   64'd0);
    check_eq("rst_pending",  64'(bus.pending_mask), 64'd0);
    check_eq("rst_ready",    64'(bus.lu_ready),     64'd1);

    // Fill FIFO with rd 3,4 behind a busy pipeline, then reset mid-operation
    clear_logs();
    busy(1'b1, 5'd3, 32'h33);
    busy(1'b1, 5'd4, 32'h44);
    check_eq("fill_pending", 64'(bus.pending_mask), 64'h18);
    check_eq("fill_ready",   64'(bus.lu_ready),     64'd0);
    check_eq("fill_we",      64'(bus.rf_we),        64'd1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_we",      64'(bus.rf_we),        64'd0);
    check_eq("mid_rst_stall",   64'(bus.pipe_stall),   64'd0);
    check_eq("mid_rst_pending", 64'(bus.pending_mask), 64'd0);
    check_eq("mid_rst_ready",   64'(bus.lu_ready),     64'd1);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    clear_logs();
    idle(3);
    check_eq("mid_rst_no_drain", 64'(wlog_q.size()), 64'd0);

    // Idle pipeline: lu rd5 appears on the port two cycles after presentation
    clear_logs();
    tick(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEAD);
    check_eq("drain_we0",      64'(bus.rf_we),        64'd0);
    check_eq("drain_pending",  64'(bus.pending_mask), 64'h20);
    idle(1);
    check_eq("drain_we1",      64'(bus.rf_we),        64'd1);
    check_eq("drain_waddr",    64'(bus.rf_waddr),     64'd5);
    check_eq("drain_wdata",    64'(bus.rf_wdata),     64'hDEAD);
    check_eq("drain_pend_clr", 64'(bus.pending_mask), 64'd0);
    idle(1);
    check_eq("drain_we2",      64'(bus.rf_we),        64'd0);

    // Starvation: continuous pipeline writes, lu rd7 forced out by age
    clear_logs();
    busy(1'b1, 5'd7, 32'h77);
    check_eq("starve_pending", 64'(bus.pending_mask), 64'h80);
    for (int k = 0; k < 14; k++) busy(1'b0, 5'd0, 32'd0);
    idle(2);
    check_eq("starve_nstall",  64'(stall_q.size()), 64'd1);
    if (stall_q.size() > 0) check_eq("starve_stall_at", 64'(stall_q[0]), 64'd8);
    check_eq("starve_nwrite",  64'(wlog_q.size()), 64'd1);
    if (wlog_q.size() > 0) begin
      check_eq("starve_w_at",   64'(wlog_q[0].edge_n), 64'd9);
      check_eq("starve_w_rd",   64'(wlog_q[0].rd),     64'd7);
      check_eq("starve_w_data", 64'(wlog_q[0].data),   64'h77);
    end

    // Full FIFO: two pushes behind busy pipeline force a drain, in order
    clear_logs();
    busy(1'b1, 5'd3, 32'h33);
    busy(1'b1, 5'd4, 32'h44);
    check_eq("full_ready",   64'(bus.lu_ready),     64'd0);
    check_eq("full_pending", 64'(bus.pending_mask), 64'h18);
    busy(1'b0, 5'd0, 32'd0);
    check_eq("full_stall",   64'(bus.pipe_stall),   64'd1);
    idle(4);
    check_eq("full_nstall",  64'(stall_q.size()), 64'd1);
    check_eq("full_nwrite",  64'(wlog_q.size()),  64'd2);
    if (wlog_q.size() == 2) begin
      check_eq("full_w0", {27'd0, wlog_q[0].rd, wlog_q[0].data}, {27'd0, 5'd3, 32'h33});
      check_eq("full_w0_at", 64'(wlog_q[0].edge_n), 64'd3);
      check_eq("full_w1", {27'd0, wlog_q[1].rd, wlog_q[1].data}, {27'd0, 5'd4, 32'h44});
      check_eq("full_w1_at", 64'(wlog_q[1].edge_n), 64'd4);
    end

    // WAW: buffered rd9 squashed by a younger pipeline write to rd9
    clear_logs();
    busy(1'b1, 5'd9, 32'h55);
    check_eq("waw_pending0", 64'(bus.pending_mask), 64'h200);
    tick(1'b1, 5'd9, 32'h1, 1'b0, 5'd0, 32'd0);
    check_eq("waw_we",       64'(bus.rf_we),        64'd1);
    check_eq("waw_waddr",    64'(bus.rf_waddr),     64'd9);
    check_eq("waw_wdata",    64'(bus.rf_wdata),     64'h1);
    check_eq("waw_pending1", 64'(bus.pending_mask), 64'd0);
    idle(3);
    check_eq("waw_nwrite",   64'(wlog_q.size()),    64'd1);
    check_eq("waw_ready",    64'(bus.lu_ready),     64'd1);

    // x0: pipeline and lu requests to rd0 never write nor occupy the FIFO
    clear_logs();
    tick(1'b1, 5'd0, 32'hBAD, 1'b1, 5'd0, 32'hBAD0);
    check_eq("x0_we0",     64'(bus.rf_we),        64'd0);
    tick(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hBAD1);
    check_eq("x0_ready",   64'(bus.lu_ready),     64'd1);
    check_eq("x0_pending", 64'(bus.pending_mask), 64'd0);
    idle(2);
    check_eq("x0_nwrite",  64'(wlog_q.size()),    64'd0);
    check_eq("x0_we1",     64'(bus.rf_we),        64'd0);

    $display("test done: total=%0d bad=%0d", total_s, bad_s);
    $finish;
  end
endmodule
